// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer with prescaler, NCMP compare channels and Cause.IP ownership.
// Build option: define CP0TIMER_EXTLATCH_EN to make synchronised external interrupt bits sticky.
module cp0_timer_cmp #(
  parameter int          CW   = 32,
  parameter logic [4:0]  ADDR = 5'd11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          phi2,
  input  logic          write,
  input  logic [4:0]    waddr,
  input  logic [CW-1:0] wdata,
  input  logic [CW-1:0] count,
  output logic [CW-1:0] cmp,
  output logic          pend
);
  // A compare write clears pending even when the old value matches this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmp  <= '1;
      pend <= 1'b0;
    end else if (phi2) begin
      if (write && waddr == ADDR) begin
        cmp  <= wdata;
        pend <= 1'b0;
      end else if (count == cmp) begin
        pend <= 1'b1;
      end
    end
  end
endmodule

module cp0_timer #(
  parameter int NCMP = 1,
  parameter int DIV  = 2,
  parameter int CW   = 32,
  parameter int NEXT = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            phi2,
  input  logic [4:0]      raddr,
  output logic [63:0]     rdata,
  input  logic [4:0]      waddr,
  input  logic [63:0]     wdata,
  input  logic            write,
  input  logic [31:0]     status,
  input  logic [NEXT-1:0] extint,
  output logic [7:0]      ip,
  output logic [NCMP-1:0] timerpend,
  output logic            irq
);
  localparam int          PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  function automatic logic [4:0] caddr(input int i);
    return (i == 0) ? 5'd11 : 5'(21 + i);
  endfunction

  logic [CW-1:0]            count;
  logic [PW-1:0]            pcnt;
  logic [NCMP-1:0][CW-1:0]  cmp;
  logic [NEXT-1:0]          s1, s2;
  logic [1:0]               sw;
  logic [4:0]               ipext;
  logic                     cause_we;
  logic                     unused_ok;

  assign cause_we  = write && waddr == 5'd13;
  assign unused_ok = ^{wdata, status};

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      pcnt  <= '0;
    end else if (phi2) begin
      if (write && waddr == 5'd9) begin
        count <= wdata[CW-1:0];
        pcnt  <= '0;
      end else if (pcnt == PMAX) begin
        count <= count + CW'(1);
        pcnt  <= '0;
      end else begin
        pcnt  <= pcnt + PW'(1);
      end
    end
  end

  for (genvar g = 0; g < NCMP; g++) begin : g_cmp
    cp0_timer_cmp #(.CW(CW), .ADDR(caddr(g))) u_cmp (
      .clk   (clk),
      .reset (reset),
      .phi2  (phi2),
      .write (write),
      .waddr (waddr),
      .wdata (wdata[CW-1:0]),
      .count (count),
      .cmp   (cmp[g]),
      .pend  (timerpend[g])
    );
  end

  // s2 is the synchronised stage; in latched builds it doubles as the sticky bit so
  // extint-to-ip latency stays at two enabled cycles and a new set beats a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      sw <= '0;
    end else if (phi2) begin
      s1 <= extint;
`ifdef CP0TIMER_EXTLATCH_EN
      s2 <= s1 | (s2 & (cause_we ? wdata[10 +: NEXT] : {NEXT{1'b1}}));
`else
      s2 <= s1;
`endif
      if (cause_we) sw <= wdata[9:8];
    end
  end

  always_comb begin
    ipext = '0;
    ipext[NEXT-1:0] = s2;
  end

  assign ip = {|timerpend, ipext, sw};

  always_ff @(posedge clk) begin
    if (reset)
      irq <= 1'b0;
    else if (phi2)
      irq <= status[0] & ~status[1] & ~status[2] & |(ip & status[15:8]);
  end

  always_comb begin
    rdata = '0;
    if (raddr == 5'd9)  rdata = 64'(count);
    if (raddr == 5'd13) rdata = {48'd0, ip, 8'd0};
    for (int i = 0; i < NCMP; i++)
      if (raddr == caddr(i)) rdata = 64'(cmp[i]);
  end
endmodule
